// File: rtl/serial_tx_pkg.sv
// Shared constants, state encoding and width helper for the serial word transmitter
// and its companion blocks.
package serial_tx_pkg;

    localparam int unsigned DEF_W = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } tx_state_e;

    // Width of a counter that must reach n-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < n) begin
            res = res + 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter: synchronous clear, count enable, saturates at W-1 and flags it.
module bit_counter
    import serial_tx_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    localparam logic [CW-1:0] MaxCnt = CW'(W - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == MaxCnt);

    // Clear takes priority so a reload on the final bit restarts at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: LSB first, one bit per clock, start-of-word and
// last-bit markers, gap-free back-to-back words.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         t_clk,
    input  logic         r,
    input  logic [W-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         so,
    output logic         sw,
    output logic         last,
    output logic         busy
);

    localparam int unsigned   CW     = clog2(W);
    localparam logic [CW-1:0] CntPen = CW'(W - 2);

    tx_state_e     r_state;
    tx_state_e     w_state_d;
    logic [W-1:0]  r_shreg;
    logic [W-1:0]  w_shreg_d;
    logic          r_sw;
    logic          r_last;
    logic          w_sw_d;
    logic          w_last_d;
    logic          w_accept;
    logic          w_cnt_en;
    logic [CW-1:0] w_cnt;
    logic          w_tc;

    assign load_ready = !r && ((r_state == StIdle) || ((r_state == StShift) && w_tc));
    assign w_accept   = load_valid && load_ready;

    bit_counter #(
        .W  (W),
        .CW (CW)
    ) u_bit_counter (
        .i_clk (t_clk),
        .i_rst (r),
        .i_clr (w_accept),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (w_tc && !w_accept) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Next values for the registered outputs; last is raised one edge early from cnt==W-2.
    always_comb begin
        w_cnt_en  = 1'b0;
        w_shreg_d = r_shreg;
        w_sw_d    = 1'b0;
        w_last_d  = 1'b0;
        if (w_accept) begin
            w_shreg_d = din;
            w_sw_d    = 1'b1;
        end else if (r_state == StShift) begin
            w_cnt_en  = 1'b1;
            w_shreg_d = r_shreg >> 1;
            w_last_d  = (w_cnt == CntPen);
        end
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_shreg <= '0;
            r_sw    <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_shreg <= w_shreg_d;
            r_sw    <= w_sw_d;
            r_last  <= w_last_d;
        end
    end

    // After the final shift without a reload the register has drained to zero, so so idles low.
    assign so   = r_shreg[0];
    assign sw   = r_sw;
    assign last = r_last;
    assign busy = (r_state == StShift);

endmodule
